// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide engine: op codes, FSM state
// encoding and the quotient returned on a divide by zero.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide engine.
// Multiply: radix-2 shift-add on {high partial product, remaining multiplier}.
// Divide: restoring shift-subtract on {partial remainder, remaining dividend};
// the quotient bit is returned separately and the lowest result bit is left 0
// so the caller can drop it in.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic                 q_bit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   top;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  // Compute both the shift-add and the shift-subtract step and pick by mode
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    top    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = top[WIDTH-1:0] - operand;
    borrow = top < {1'b0, operand};
    q_bit  = ~borrow;
    if (is_div) begin
      acc_next = {(borrow ? top[WIDTH-1:0] : diff), acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning the CPU's HI/LO registers.
// Signed operands are converted to magnitudes on entry, the unsigned core
// iterates WIDTH times, and signs are re-applied in the FIX state.
// Optional macro HILO_WRITE_EN adds MTHI/MTLO write ports (idle-only writes).
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef HILO_WRITE_EN
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               div0;
  logic               neg_q;
  logic               neg_r;
  logic               done;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // Operand magnitudes; unsigned ops pass the raw bits straight through
  always_comb begin
    signed_op = ~op_i[0];
    a_mag     = (signed_op && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag     = (signed_op && b_i[WIDTH-1]) ? -b_i : b_i;
  end

  // Sign correction and result selection written to HI/LO in FIX
  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (div0) begin
      hi_res = acc[WIDTH-1:0];
      lo_res = WIDTH'(DIV0_LO);
    end else if (is_div) begin
      hi_res = rem;
      lo_res = quo;
    end else begin
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
    end
  end

  // Control FSM with iteration counter and working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      div0    <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      done    <= 1'b0;
      acc     <= '0;
      operand <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            is_div <= op_i[1];
            cnt    <= '0;
            neg_q  <= signed_op & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_r  <= signed_op & a_i[WIDTH-1];
            if (op_i[1] && (b_i == '0)) begin
              div0    <= 1'b1;
              acc     <= {{WIDTH{1'b0}}, a_i};
              operand <= '0;
              state   <= S_FIX;
            end else begin
              div0  <= 1'b0;
              state <= S_CALC;
              if (op_i[1]) begin
                acc     <= {{WIDTH{1'b0}}, a_mag};
                operand <= b_mag;
              end else begin
                acc     <= {{WIDTH{1'b0}}, b_mag};
                operand <= a_mag;
              end
            end
          end
        end
        S_CALC: begin
          acc <= {step_acc[2*WIDTH-1:1], (is_div ? step_q : step_acc[0])};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // HI/LO architectural registers: result at FIX, optional direct write when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      hi <= hi_res;
      lo <= lo_res;
    end
`ifdef HILO_WRITE_EN
    else if (state == S_IDLE) begin
      if (hi_we_i) hi <= wdata_i;
      if (lo_we_i) lo <= wdata_i;
    end
`endif
  end

  assign busy_o  = (state != S_IDLE);
  assign done_o  = done;
  assign stall_o = busy_o | start_i;
  assign hi_o    = hi;
  assign lo_o    = lo;

endmodule
